// File: rtl/riscv_test_sequencer_if.sv
// Preload stream, external data-memory write port and CPU store snoop bundled for the test sequencer.
// master is the sequencer side; slave is the test source / CPU side.
interface riscv_test_sequencer_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] DataAdr;

  modport master (
    input  ld_valid, ld_data, MemWrite, WriteData, DataAdr,
    output ld_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );

  modport slave (
    output ld_valid, ld_data, MemWrite, WriteData, DataAdr,
    input  ld_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );
endinterface

// File: rtl/riscv_test_sequencer.sv
// Preload-and-check harness: streams parameter words into CPU data memory, releases the CPU and
// watches result/done mailbox stores for a sticky pass/fail/timeout verdict.
module riscv_test_sequencer #(
  parameter int unsigned NUM_WORDS      = 5,
  parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
  parameter logic [31:0] RESULT_OFFSET  = 32'h0000_000C,
  parameter logic [31:0] DONE_OFFSET    = 32'h0000_0010,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [31:0]                    expected,
  output logic                           cpu_reset,
  output logic                           busy,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [31:0]                    cycle_count,
  riscv_test_sequencer_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_RELEASE, S_RUN, S_PASS, S_FAIL
  } state_t;

  localparam logic [31:0] RESULT_ADDR = BASE_ADDR + RESULT_OFFSET;
  localparam logic [31:0] DONE_ADDR   = BASE_ADDR + DONE_OFFSET;

  state_t      state, state_next;
  logic [7:0]  index;
  logic [8:0]  index_inc;
  logic [31:0] expected_q;
  logic        result_seen, result_ok;
  logic        load_fire, start_fire, result_hit, done_hit, timeout_hit;

  assign bus.ld_ready = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    index_inc   = {1'b0, index} + 9'd1;
    load_fire   = bus.ld_valid && (state == S_LOAD);
    start_fire  = start && (state == S_IDLE || state == S_PASS || state == S_FAIL);
    result_hit  = bus.MemWrite && (bus.DataAdr == RESULT_ADDR);
    done_hit    = bus.MemWrite && (bus.DataAdr == DONE_ADDR) && (bus.WriteData == 32'd1);
    timeout_hit = (cycle_count == TIMEOUT_CYCLES - 32'd1);
    unique case (state)
      S_IDLE:    if (start_fire) state_next = S_LOAD;
      S_LOAD:    if (load_fire) state_next = S_GAP;
      S_GAP:     state_next = ({23'd0, index_inc} < NUM_WORDS) ? S_LOAD : S_RELEASE;
      S_RELEASE: state_next = S_RUN;
      S_RUN: begin
        // a done store in the timeout cycle takes precedence over the timeout
        if (done_hit)         state_next = (result_seen && result_ok) ? S_PASS : S_FAIL;
        else if (timeout_hit) state_next = S_FAIL;
      end
      S_PASS, S_FAIL: if (start_fire) state_next = S_LOAD;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_reset         <= 1'b1;
      busy              <= 1'b0;
      pass              <= 1'b0;
      fail              <= 1'b0;
      timeout           <= 1'b0;
      cycle_count       <= '0;
      index             <= '0;
      expected_q        <= '0;
      result_seen       <= 1'b0;
      result_ok         <= 1'b0;
      bus.Ext_MemWrite  <= 1'b0;
      bus.Ext_WriteData <= '0;
      bus.Ext_DataAdr   <= '0;
    end else begin
      // registered outputs track the state being entered
      cpu_reset <= (state_next != S_RUN);
      busy      <= (state_next == S_LOAD) || (state_next == S_GAP) ||
                   (state_next == S_RELEASE) || (state_next == S_RUN);

      bus.Ext_MemWrite  <= 1'b0;
      bus.Ext_WriteData <= '0;
      bus.Ext_DataAdr   <= '0;
      if (load_fire) begin
        bus.Ext_MemWrite  <= 1'b1;
        bus.Ext_WriteData <= bus.ld_data;
        bus.Ext_DataAdr   <= BASE_ADDR + {22'd0, index, 2'b00};
      end

      if (state == S_GAP) index <= index_inc[7:0];

      if (start_fire) begin
        expected_q  <= expected;
        pass        <= 1'b0;
        fail        <= 1'b0;
        timeout     <= 1'b0;
        cycle_count <= '0;
        index       <= '0;
        result_seen <= 1'b0;
        result_ok   <= 1'b0;
      end

      if (state == S_RUN) begin
        cycle_count <= cycle_count + 32'd1;
        if (result_hit) begin
          result_seen <= 1'b1;
          result_ok   <= (bus.WriteData == expected_q);
        end
        if (state_next == S_PASS) pass <= 1'b1;
        if (state_next == S_FAIL) begin
          fail    <= 1'b1;
          timeout <= !done_hit;
        end
      end
    end
  end

endmodule
